// File: rtl/bird_life_if.sv
// bird_life_if: game-side pulses in, drawer/game status out of the bird life controller
interface bird_life_if;
    logic       startOfFrame;
    logic       spawn;
    logic       hit;
    logic       kill;
    logic       alive;
    logic       flash;
    logic       duty50;
    logic [2:0] lives;
    logic       died;
    modport master (output startOfFrame, spawn, hit, kill, input alive, flash, duty50, lives, died);
    modport slave  (input startOfFrame, spawn, hit, kill, output alive, flash, duty50, lives, died);
endinterface

// File: rtl/bird_life_ctrl.sv
// bird_life_ctrl: frame-paced spawn/fly/hit-flash/dying/dead sequencer for one bird
module bird_life_ctrl #(
    parameter int LIVES        = 3,
    parameter int FLASH_FRAMES = 16,
    parameter int DYING_FRAMES = 32,
    parameter int FLAP_FRAMES  = 8
) (
    input  logic      clk,
    input  logic      resetN,
    bird_life_if.slave bus
);
    typedef enum logic [1:0] {DEAD, FLY, HIT, DYING} state_t;
    localparam logic [7:0] FLASH_LD = 8'(FLASH_FRAMES);
    localparam logic [7:0] DYING_LD = 8'(DYING_FRAMES);
    localparam logic [7:0] FLAP_TOP = 8'(FLAP_FRAMES - 1);
    state_t     state;
    logic [7:0] frame_cnt;
    logic [7:0] flap_cnt;
    logic [7:0] frame_dec;
    logic       flap_end;
    assign frame_dec = frame_cnt - 8'd1;
    assign flap_end  = flap_cnt == FLAP_TOP;
    // Single-process state machine; every output is a register updated alongside the state
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= DEAD;
            frame_cnt  <= '0;
            flap_cnt   <= '0;
            bus.alive  <= 1'b0;
            bus.flash  <= 1'b0;
            bus.duty50 <= 1'b0;
            bus.lives  <= '0;
            bus.died   <= 1'b0;
        end else begin
            bus.died <= 1'b0;
            case (state)
                DEAD: begin
                    flap_cnt <= '0;
                    if (bus.spawn) begin
                        state      <= FLY;
                        bus.alive  <= 1'b1;
                        bus.lives  <= 3'(LIVES);
                        bus.duty50 <= 1'b1;
                    end
                end
                FLY, HIT: begin
                    if (bus.startOfFrame) begin
                        flap_cnt <= flap_end ? 8'd0 : flap_cnt + 8'd1;
                        if (flap_end) bus.duty50 <= ~bus.duty50;
                    end
                    if (bus.kill || (state == FLY && bus.hit && bus.lives == 3'd1)) begin
                        state     <= DYING;
                        bus.lives <= '0;
                        frame_cnt <= DYING_LD;
                        bus.flash <= DYING_LD[2];
                    end else if (state == FLY && bus.hit) begin
                        state     <= HIT;
                        bus.lives <= bus.lives - 3'd1;
                        frame_cnt <= FLASH_LD;
                        bus.flash <= 1'b1;
                    end else if (state == HIT && bus.startOfFrame) begin
                        if (frame_cnt == 8'd1) begin
                            state     <= FLY;
                            bus.flash <= 1'b0;
                        end
                        frame_cnt <= frame_dec;
                    end
                end
                DYING: begin
                    if (bus.startOfFrame) begin
                        frame_cnt <= frame_dec;
                        if (frame_cnt == 8'd1) begin
                            state      <= DEAD;
                            bus.died   <= 1'b1;
                            bus.alive  <= 1'b0;
                            bus.flash  <= 1'b0;
                            bus.duty50 <= 1'b0;
                        end else begin
                            bus.flash <= frame_dec[2];
                        end
                    end
                end
                default: state <= DEAD;
            endcase
        end
    end
endmodule

// File: tb/tb_bird_life_ctrl.sv
// tb_bird_life_ctrl: directed vector table plus hand-written multi-frame sequences
module tb_bird_life_ctrl;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ns;
    logic d0;
    bird_life_if bus();
    bird_life_ctrl dut (.clk(clk), .resetN(resetN), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic       rn, sof, sp, h, k;
        logic [6:0] exp;
    } vec_t;
    vec_t v[13];

    function automatic logic [6:0] e(input logic a, f, d, input logic [2:0] l, input logic dd);
        return {a, f, d, l, dd};
    endfunction

    task automatic step(input logic rn, sof, sp, h, k);
        resetN = rn;
        bus.startOfFrame = sof;
        bus.spawn = sp;
        bus.hit = h;
        bus.kill = k;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [6:0] exp);
        logic [6:0] act;
        act = {bus.alive, bus.flash, bus.duty50, bus.lives, bus.died};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual(alive,flash,duty50,lives,died)=%b required=%b", n, act, exp);
        end
    endtask

    initial begin
        bus.startOfFrame = 1'b0;
        bus.spawn = 1'b0;
        bus.hit = 1'b0;
        bus.kill = 1'b0;
        v[0]  = '{0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)};
        v[1]  = '{1, 0, 0, 1, 0, e(0, 0, 0, 0, 0)};
        v[2]  = '{1, 0, 0, 0, 1, e(0, 0, 0, 0, 0)};
        v[3]  = '{1, 0, 1, 0, 0, e(1, 0, 1, 3, 0)};
        v[4]  = '{1, 0, 1, 0, 0, e(1, 0, 1, 3, 0)};
        v[5]  = '{1, 1, 0, 0, 0, e(1, 0, 1, 3, 0)};
        v[6]  = '{1, 0, 0, 1, 0, e(1, 1, 1, 2, 0)};
        v[7]  = '{1, 0, 0, 1, 0, e(1, 1, 1, 2, 0)};
        v[8]  = '{1, 0, 1, 0, 0, e(1, 1, 1, 2, 0)};
        v[9]  = '{1, 0, 0, 0, 1, e(1, 0, 1, 0, 0)};
        v[10] = '{1, 1, 0, 0, 0, e(1, 1, 1, 0, 0)};
        v[11] = '{1, 0, 1, 0, 0, e(1, 1, 1, 0, 0)};
        v[12] = '{0, 0, 0, 0, 0, e(0, 0, 0, 0, 0)};
        for (int i = 0; i < 13; i++) begin
            step(v[i].rn, v[i].sof, v[i].sp, v[i].h, v[i].k);
            chk($sformatf("vec%0d", i), v[i].exp);
        end

        step(1, 0, 1, 0, 0);
        ns = 0;
        chk("spawn", e(1, 0, 1, 3, 0));
        for (int k = 1; k <= 16; k++) begin
            step(1, 1, 0, 0, 0);
            ns++;
            chk($sformatf("flap%0d", k), e(1, 0, ((ns / 8) % 2) == 0, 3, 0));
        end

        step(1, 0, 0, 1, 0);
        chk("hit1", e(1, 1, ((ns / 8) % 2) == 0, 2, 0));
        for (int k = 1; k <= 16; k++) begin
            step(1, 1, 0, 0, 0);
            ns++;
            chk($sformatf("flash%0d", k), e(1, k < 16, ((ns / 8) % 2) == 0, 2, 0));
            if (k == 3) begin
                step(1, 0, 0, 1, 0);
                chk("rehit", e(1, 1, ((ns / 8) % 2) == 0, 2, 0));
            end
        end

        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 1, 0);
            chk($sformatf("held%0d", k), e(1, 1, ((ns / 8) % 2) == 0, 1, 0));
        end
        for (int k = 1; k <= 16; k++) begin
            step(1, 1, 0, 0, 0);
            ns++;
        end
        chk("held_end", e(1, 0, ((ns / 8) % 2) == 0, 1, 0));

        step(1, 0, 0, 1, 0);
        d0 = ((ns / 8) % 2) == 0;
        chk("last_hit", e(1, 0, d0, 0, 0));
        for (int k = 1; k <= 32; k++) begin
            step(1, 1, 0, 0, 0);
            if (k < 32) chk($sformatf("dying%0d", k), e(1, ((32 - k) >> 2) & 1, d0, 0, 0));
            else chk("died", e(0, 0, 0, 0, 1));
        end
        step(1, 0, 0, 0, 0);
        chk("died_gone", e(0, 0, 0, 0, 0));

        step(1, 0, 1, 0, 0);
        chk("respawn", e(1, 0, 1, 3, 0));
        step(1, 0, 0, 1, 1);
        chk("kill_hit", e(1, 0, 1, 0, 0));
        step(1, 0, 1, 0, 0);
        chk("spawn_dying", e(1, 0, 1, 0, 0));
        step(1, 1, 0, 0, 0);
        chk("dying_blink", e(1, 1, 1, 0, 0));

        step(0, 0, 0, 0, 0);
        chk("reset2", e(0, 0, 0, 0, 0));
        step(1, 0, 1, 0, 0);
        ns = 0;
        for (int k = 0; k < 7; k++) begin
            step(1, 1, 0, 0, 0);
            ns++;
        end
        step(1, 1, 0, 1, 0);
        ns++;
        chk("hit_sof", e(1, 1, 0, 2, 0));
        for (int k = 0; k < 15; k++) begin
            step(1, 1, 0, 0, 0);
            ns++;
        end
        chk("hit_sof_load", e(1, 1, ((ns / 8) % 2) == 0, 2, 0));
        step(0, 0, 0, 0, 0);
        chk("reset_hit", e(0, 0, 0, 0, 0));
        step(1, 0, 0, 0, 0);
        chk("reset_nodied", e(0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
